// File: rtl/ball_layer_compositor_if.sv
// Object-bitmap to compositor bundle: per-object draw requests and colours in,
// the final pixel and the per-frame hit pulses out.
interface ball_layer_compositor_if #(
    parameter int NUM_BALLS = 4
);
    logic                     startOfFrame;
    logic [NUM_BALLS-1:0]     ballDrawingRequest;
    logic [NUM_BALLS*8-1:0]   ballRGB;
    logic                     playerDrawingRequest;
    logic [7:0]               playerRGB;
    logic                     ropeDrawingRequest;
    logic [7:0]               ropeRGB;
    logic [7:0]               backgroundRGB;
    logic [7:0]               RGBOut;
    logic [NUM_BALLS-1:0]     ropeHitBall;
    logic                     playerHitBall;

    // Producer side: VGA timing, object bitmaps and the downstream consumers.
    modport master (
        output startOfFrame,
        output ballDrawingRequest,
        output ballRGB,
        output playerDrawingRequest,
        output playerRGB,
        output ropeDrawingRequest,
        output ropeRGB,
        output backgroundRGB,
        input  RGBOut,
        input  ropeHitBall,
        input  playerHitBall
    );

    // Compositor side.
    modport slave (
        input  startOfFrame,
        input  ballDrawingRequest,
        input  ballRGB,
        input  playerDrawingRequest,
        input  playerRGB,
        input  ropeDrawingRequest,
        input  ropeRGB,
        input  backgroundRGB,
        output RGBOut,
        output ropeHitBall,
        output playerHitBall
    );
endinterface

// File: rtl/ball_layer_compositor.sv
// Ball layer compositor: priority pixel mux (player > rope > balls > background)
// and once-per-frame overlap detection between the balls and the rope/player.
// All outputs are registered, one pixel clock behind the inputs.
//
// state      | meaning
// WAIT_FRAME | after reset; mux runs, hit detection off until a full frame starts
// ACTIVE     | hit detection enabled; left only by reset
module ball_layer_compositor #(
    parameter int         NUM_BALLS            = 4,
    parameter logic [7:0] TRANSPARENT_ENCODING = 8'hFF
) (
    input logic                    clk,
    input logic                    resetN,
    ball_layer_compositor_if.slave bus
);

    localparam logic [0:0] WAIT_FRAME = 1'b0;
    localparam logic [0:0] ACTIVE     = 1'b1;

    logic [0:0]           state;
    logic [0:0]           state_next;
    logic                 detect_en;

    logic [NUM_BALLS-1:0] ropeFlag;
    logic [NUM_BALLS-1:0] ropeFlag_live;
    logic [NUM_BALLS-1:0] ropeFlag_next;
    logic [NUM_BALLS-1:0] ropeHit_next;
    logic                 playerFlag;
    logic                 playerFlag_live;
    logic                 playerFlag_next;
    logic                 playerHit_next;

    logic [7:0]           pixel_next;
    logic [7:0]           RGBOut_q;
    logic [NUM_BALLS-1:0] ropeHitBall_q;
    logic                 playerHitBall_q;

    assign bus.RGBOut        = RGBOut_q;
    assign bus.ropeHitBall   = ropeHitBall_q;
    assign bus.playerHitBall = playerHitBall_q;

    // Next-state logic: the first startOfFrame after reset opens detection for good.
    always_comb begin
        state_next = state;
        if (state == WAIT_FRAME && bus.startOfFrame) begin
            state_next = ACTIVE;
        end
    end

    // The startOfFrame cycle is already the first pixel of a complete frame,
    // so detection is trusted there even while still leaving WAIT_FRAME.
    assign detect_en = (state == ACTIVE) || bus.startOfFrame;

    // Frame start wipes the old frame's flags before this cycle's overlap is
    // judged, so an overlap on the very first pixel is a fresh hit.
    assign ropeFlag_live   = bus.startOfFrame ? '0   : ropeFlag;
    assign playerFlag_live = bus.startOfFrame ? 1'b0 : playerFlag;

    // Overlap detection runs on raw draw requests, independent of mux priority.
    always_comb begin
        ropeHit_next   = '0;
        playerHit_next = 1'b0;
        if (detect_en) begin
            ropeHit_next   = bus.ballDrawingRequest & ~ropeFlag_live
                             & {NUM_BALLS{bus.ropeDrawingRequest}};
            playerHit_next = bus.playerDrawingRequest & (|bus.ballDrawingRequest)
                             & ~playerFlag_live;
        end
        ropeFlag_next   = ropeFlag_live | ropeHit_next;
        playerFlag_next = playerFlag_live | playerHit_next;
    end

    // Priority mux, built lowest priority first so later assignments win.
    always_comb begin
        pixel_next = (bus.backgroundRGB == TRANSPARENT_ENCODING) ? 8'h00 : bus.backgroundRGB;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (bus.ballDrawingRequest[i]) begin
                pixel_next = bus.ballRGB[8*i +: 8];
            end
        end
        if (bus.ropeDrawingRequest) begin
            pixel_next = bus.ropeRGB;
        end
        if (bus.playerDrawingRequest) begin
            pixel_next = bus.playerRGB;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    // Per-frame hit flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ropeFlag   <= '0;
            playerFlag <= 1'b0;
        end else begin
            ropeFlag   <= ropeFlag_next;
            playerFlag <= playerFlag_next;
        end
    end

    // Output registers: pixel and single-cycle hit pulses share the same latency.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGBOut_q        <= 8'h00;
            ropeHitBall_q   <= '0;
            playerHitBall_q <= 1'b0;
        end else begin
            RGBOut_q        <= pixel_next;
            ropeHitBall_q   <= ropeHit_next;
            playerHitBall_q <= playerHit_next;
        end
    end

endmodule

// File: tb/tb_ball_layer_compositor.sv
// Directed bench for ball_layer_compositor: stimulus pushes hand-computed
// expected outputs into a queue, an independent monitor pops one per clock.
module tb_ball_layer_compositor;

    logic clk;
    logic resetN;

    ball_layer_compositor_if #(.NUM_BALLS(4)) bus ();

    ball_layer_compositor #(
        .NUM_BALLS(4),
        .TRANSPARENT_ENCODING(8'hFF)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] rgb;
        logic [3:0] rope;
        logic       ph;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   vec_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int id, input logic [7:0] rgb_e,
                         input logic [3:0] rope_e, input logic ph_e);
        n_vec++;
        if (bus.RGBOut !== rgb_e || bus.ropeHitBall !== rope_e || bus.playerHitBall !== ph_e) begin
            n_miss++;
            $display("FAIL %s #%0d: got rgb=%h rope=%b player=%b, want rgb=%h rope=%b player=%b",
                     nm, id, bus.RGBOut, bus.ropeHitBall, bus.playerHitBall, rgb_e, rope_e, ph_e);
        end
    endtask

    // One clock of stimulus; the expected registered response is queued.
    task automatic drive(input logic sof, input logic [3:0] breq, input logic preq,
                         input logic rreq, input logic [7:0] bg, input logic [7:0] e_rgb,
                         input logic [3:0] e_rope, input logic e_ph);
        exp_t e;
        @(negedge clk);
        bus.startOfFrame         = sof;
        bus.ballDrawingRequest   = breq;
        bus.playerDrawingRequest = preq;
        bus.ropeDrawingRequest   = rreq;
        bus.backgroundRGB        = bg;
        e.id   = vec_id;
        e.rgb  = e_rgb;
        e.rope = e_rope;
        e.ph   = e_ph;
        vec_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected entry per clock, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("vec", e.id, e.rgb, e.rope, e.ph);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetN                   = 1'b0;
        bus.startOfFrame         = 1'b0;
        bus.ballDrawingRequest   = 4'b0000;
        bus.ballRGB              = {8'h33, 8'h5A, 8'h9B, 8'h72};
        bus.playerDrawingRequest = 1'b0;
        bus.playerRGB            = 8'hE0;
        bus.ropeDrawingRequest   = 1'b0;
        bus.ropeRGB              = 8'hC3;
        bus.backgroundRGB        = 8'h24;

        repeat (3) @(posedge clk);
        #2;
        check("in_reset", 0, 8'h00, 4'b0000, 1'b0);
        resetN = 1'b1;

        // Reset release and priority mux
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0010, 0, 0, 8'h24, 8'h9B, 4'b0000, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(0, 4'b0001, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(0, 4'b0110, 0, 0, 8'h24, 8'h9B, 4'b0000, 0);
        drive(0, 4'b0000, 0, 0, 8'hFF, 8'h00, 4'b0000, 0);
        drive(0, 4'b1000, 0, 0, 8'hFF, 8'h33, 4'b0000, 0);

        // No detection before the first startOfFrame
        for (int i = 0; i < 10; i++) drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(1, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0100, 0);
        drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);

        // Player hit once per frame across three overlap runs
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 1);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(0, 4'b1100, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(1, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 1);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);

        // Two balls hit by the rope in one cycle
        drive(0, 4'b1001, 0, 1, 8'h24, 8'hC3, 4'b1001, 0);
        drive(0, 4'b1001, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);

        // Player hides the rope but the rope overlap still counts
        drive(0, 4'b0100, 1, 1, 8'h24, 8'hE0, 4'b0100, 0);
        drive(0, 4'b0100, 1, 1, 8'h24, 8'hE0, 4'b0000, 0);

        // Frame boundary: overlap on the startOfFrame cycle is a new-frame hit
        drive(0, 4'b0010, 0, 1, 8'h24, 8'hC3, 4'b0010, 0);
        drive(0, 4'b0010, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(1, 4'b0010, 0, 1, 8'h24, 8'hC3, 4'b0010, 0);
        drive(0, 4'b0010, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(1, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 1);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);

        // Mid-frame reset
        drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0100, 0);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        check("async_reset", vec_id, 8'h00, 4'b0000, 1'b0);
        @(posedge clk);
        #3;
        resetN = 1'b1;
        drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0000, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 0);
        drive(1, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);
        drive(0, 4'b0100, 0, 1, 8'h24, 8'hC3, 4'b0100, 0);
        drive(0, 4'b0001, 1, 0, 8'h24, 8'hE0, 4'b0000, 1);
        drive(0, 4'b0000, 0, 0, 8'h24, 8'h24, 4'b0000, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ball_layer_compositor.md
Name: ball_layer_compositor

Overview:
- Consumer end of the object bitmap interface: takes each object's registered drawingRequest/RGB pair and selects one final pixel per clock for the VGA output.
- Detects per-frame overlaps between balls and the rope or the player, and reports each one as a single-cycle hit pulse.
- Sits between the object bitmap blocks (balls, player, rope, background) and the VGA controller, and feeds the game-logic FSM.

Parameters:
- NUM_BALLS, 4, number of ball object inputs; valid range 1-8.
- TRANSPARENT_ENCODING, 8'hFF, RGB code treated as "no pixel"; used only for backgroundRGB fallback.

Ports:
- clk  in  1  system clock (pixel clock domain)
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  single-cycle pulse from VGA controller at first pixel of a frame
- ballDrawingRequest  in  NUM_BALLS  per-ball draw request; bit i belongs to ball i
- ballRGB  in  NUM_BALLS*8  per-ball colour; ball i occupies bits [8i+7:8i]
- playerDrawingRequest  in  1  player draw request
- playerRGB  in  8  player colour
- ropeDrawingRequest  in  1  rope draw request
- ropeRGB  in  8  rope colour
- backgroundRGB  in  8  background colour, always valid
- RGBOut  out  8  selected pixel colour to VGA
- ropeHitBall  out  NUM_BALLS  bit i pulses for 1 cycle when the rope first overlaps ball i in a frame
- playerHitBall  out  1  pulses for 1 cycle when the player first overlaps any ball in a frame

Behaviour:
- Reset (async, resetN=0):
  - RGBOut=8'h00, ropeHitBall=0, playerHitBall=0.
  - All per-frame flags cleared; FSM goes to WAIT_FRAME.
  - Applies immediately, including mid-frame.
- Pixel mux:
  - Priority: player > rope > ball 0 > ball 1 > … > ball NUM_BALLS-1 > background.
  - Selection is by drawingRequest only; RGB values of non-requesting inputs are ignored.
  - If backgroundRGB==TRANSPARENT_ENCODING and nothing requests, output 8'h00.
  - RGBOut is registered: exactly 1 cycle latency from inputs.
- FSM, 2 states:
  - WAIT_FRAME (after reset): RGBOut muxing runs normally; all hit detection is suppressed, because a partial frame is untrusted. Moves to ACTIVE on startOfFrame.
  - ACTIVE: detection enabled. Stays in ACTIVE until reset.
- Per-frame flags:
  - ropeFlag[NUM_BALLS] and playerFlag, all cleared on every startOfFrame.
- Rope hit:
  - In ACTIVE, if ropeDrawingRequest && ballDrawingRequest[i] && !ropeFlag[i], then on the next edge set ropeFlag[i] and drive ropeHitBall[i]=1 for exactly one cycle.
  - Several balls may pulse in the same cycle.
  - Hit pulses have the same 1-cycle latency as RGBOut.
- Player hit:
  - Same rule using playerDrawingRequest && |ballDrawingRequest. At most one pulse per frame regardless of how many balls overlap.
- Priority does not mask detection: overlap counts even when the player hides the rope.
- Simultaneous startOfFrame and overlap in the same cycle:
  - The clear takes precedence for the old frame.
  - The overlap counts as the first hit of the new frame: pulse asserted, flag set.
- Outputs are 0 in every cycle that carries no new hit; pulses never stretch across cycles.
- No combinational path from inputs to any output.

Test Plan:
- Reset/priority: release reset; drive backgroundRGB=8'h24 with no requests, then ball1 request with RGB=8'h9B -> RGBOut 8'h00 during reset, 8'h24 one cycle later, then 8'h9B one cycle after ball1 asserts. Then assert ball0 (8'h72) together with player (8'hE0) -> RGBOut=8'hE0.
- Pre-frame suppression: after reset, overlap rope and ball2 for 10 cycles before any startOfFrame -> ropeHitBall stays 0. Pulse startOfFrame, repeat overlap -> ropeHitBall=4'b0100 for exactly 1 cycle, 1 cycle after first overlap.
- Once per frame: in ACTIVE, overlap player with ball0 for 3 separate runs within one frame -> exactly one playerHitBall pulse. Next startOfFrame plus overlap -> one new pulse.
- Multi-ball: rope overlaps balls 0 and 3 in the same cycle -> ropeHitBall=4'b1001 for 1 cycle.
- Frame boundary: assert startOfFrame in the same cycle as rope/ball1 overlap, with ropeFlag[1] already set -> ropeHitBall[1] pulses next cycle.
- Mid-frame reset: set flags, pulse resetN low for 1 cycle mid-frame -> outputs 0 immediately; overlaps ignored until the next startOfFrame.
